masked_data_queue: RTL

- Parametrised FIFO carrying a byte-mask plus data word per entry.
- Successor to the fixed 8-deep, 64-bit mask/data queue used on store/write-data paths.
- Adds configurable width and depth, flow-through and pipe modes, synchronous flush, an occupancy count and an almost-full flag.
- Sits between the LSU write-data producers and the memory-side write channel.

---
 rtl/masked_data_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/masked_data_queue.sv
// masked_data_queue: parametrised FIFO holding a {data, mask} pair per entry.
// Optional FLOW (empty-queue bypass) and PIPE (accept while full and draining)
// modes, synchronous flush, occupancy count and almost-full flag.
// Optional feature macro: MASKED_QUEUE_HWM_EN adds io_hwm, the high-water
// mark of io_count, cleared by reset only.
module masked_data_queue #(
    parameter int DATA_W    = 64,
    parameter int MASK_W    = DATA_W / 8,
    parameter int DEPTH     = 8,
    parameter int FLOW      = 0,
    parameter int PIPE      = 0,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_flush,
    output logic                     io_enq_ready,
    input  logic                     io_enq_valid,
    input  logic [MASK_W-1:0]        io_enq_bits_mask,
    input  logic [DATA_W-1:0]        io_enq_bits_data,
    input  logic                     io_deq_ready,
    output logic                     io_deq_valid,
    output logic [MASK_W-1:0]        io_deq_bits_mask,
    output logic [DATA_W-1:0]        io_deq_bits_data,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_almost_full
`ifdef MASKED_QUEUE_HWM_EN
    ,
    output logic [$clog2(DEPTH):0]   io_hwm
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + MASK_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic FLOW_EN = (FLOW != 0);
    localparam logic PIPE_EN = (PIPE != 0);

    // Pointer and occupancy state
    logic [PTR_W-1:0] enq_ptr_r;
    logic [PTR_W-1:0] deq_ptr_r;
    logic             maybe_full_r;

    // Entry storage, mask packed in the low bits
    logic [ENT_W-1:0] mem_r [DEPTH];

    logic             ptr_match_s;
    logic             empty_s;
    logic             full_s;
    logic             do_enq_s;
    logic             do_deq_s;
    logic             bypass_s;
    logic             enq_adv_s;
    logic             deq_adv_s;
    logic [ENT_W-1:0] enq_entry_s;
    logic [ENT_W-1:0] head_s;
    logic [PTR_W-1:0] ptr_diff_s;
    logic [CNT_W-1:0] count_s;

    // Derive empty/full from the pointer pair and the wrap-disambiguation flag
    always_comb begin
        ptr_match_s = (enq_ptr_r == deq_ptr_r);
        empty_s     = ptr_match_s & ~maybe_full_r;
        full_s      = ptr_match_s & maybe_full_r;
    end

    // Ready/valid generation; flush blocks both sides regardless of mode
    always_comb begin
        io_enq_ready = 1'b0;
        io_deq_valid = 1'b0;
        if (io_flush) begin
            io_enq_ready = 1'b0;
            io_deq_valid = 1'b0;
        end else begin
            if (PIPE_EN) begin
                io_enq_ready = ~full_s | io_deq_ready;
            end else begin
                io_enq_ready = ~full_s;
            end
            if (FLOW_EN && empty_s) begin
                io_deq_valid = io_enq_valid;
            end else begin
                io_deq_valid = ~empty_s;
            end
        end
    end

    // Handshakes; a bypassed entry never touches storage or pointers
    always_comb begin
        do_enq_s  = io_enq_ready & io_enq_valid;
        do_deq_s  = io_deq_ready & io_deq_valid;
        bypass_s  = FLOW_EN & empty_s & do_deq_s;
        enq_adv_s = do_enq_s & ~bypass_s;
        deq_adv_s = do_deq_s & ~bypass_s;
    end

    // Head entry selection: the producer's word when bypassing, else storage
    always_comb begin
        enq_entry_s = {io_enq_bits_data, io_enq_bits_mask};
        head_s      = mem_r[deq_ptr_r];
        if (FLOW_EN && empty_s) begin
            io_deq_bits_mask = io_enq_bits_mask;
            io_deq_bits_data = io_enq_bits_data;
        end else begin
            io_deq_bits_mask = head_s[MASK_W-1:0];
            io_deq_bits_data = head_s[ENT_W-1:MASK_W];
        end
    end

    // Occupancy from registered state only
    always_comb begin
        ptr_diff_s = enq_ptr_r - deq_ptr_r;
        if (full_s) begin
            count_s = DEPTH_CNT;
        end else begin
            count_s = {1'b0, ptr_diff_s};
        end
        io_count       = count_s;
        io_almost_full = (count_s >= AF_CNT);
    end

    // Pointer and full-flag update; reset outranks flush
    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr_r    <= {PTR_W{1'b0}};
            deq_ptr_r    <= {PTR_W{1'b0}};
            maybe_full_r <= 1'b0;
        end else if (io_flush) begin
            enq_ptr_r    <= {PTR_W{1'b0}};
            deq_ptr_r    <= {PTR_W{1'b0}};
            maybe_full_r <= 1'b0;
        end else begin
            if (enq_adv_s) begin
                enq_ptr_r <= enq_ptr_r + PTR_W'(1);
            end
            if (deq_adv_s) begin
                deq_ptr_r <= deq_ptr_r + PTR_W'(1);
            end
            if (enq_adv_s != deq_adv_s) begin
                maybe_full_r <= enq_adv_s;
            end
        end
    end

    // Storage write at the tail; in PIPE mode while full this is the slot being freed
    always_ff @(posedge clock) begin
        if (enq_adv_s) begin
            mem_r[enq_ptr_r] <= enq_entry_s;
        end
    end

`ifdef MASKED_QUEUE_HWM_EN
    logic [CNT_W-1:0] hwm_r;

    // High-water mark of occupancy; survives flush, cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            hwm_r <= {CNT_W{1'b0}};
        end else if (count_s > hwm_r) begin
            hwm_r <= count_s;
        end
    end

    assign io_hwm = hwm_r;
`endif

endmodule
